// File: rtl/vtm_pkg.sv
// Shared types and constants for the video timing monitor.
package vtm_pkg;

  typedef enum logic [0:0] {S_SYNC, S_MEAS} state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int unsigned FCNT_W   = 16;

endpackage

// File: rtl/vtm_crc16.sv
// Combinational CRC-16-CCITT step over one W-bit word, MSB first.
module vtm_crc16
  import vtm_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [15:0]  crc_in,
  input  logic [W-1:0] data,
  output logic [15:0]  crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/vid_timing_monitor.sv
// Measures per-frame line/frame timing of a raw hs/vs/vld stream and publishes one record per frame.
// Optional pixel CRC-16 is built only when VTM_CRC_EN is defined.
module vid_timing_monitor
  import vtm_pkg::*;
#(
  parameter int unsigned PW     = 8,
  parameter int unsigned H_BITS = 12,
  parameter int unsigned V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs,
  input  logic              vs,
  input  logic              vld,
  input  logic [3*PW-1:0]   rgb,
  output logic              meas_vld,
  output logic [H_BITS-1:0] meas_h_total,
  output logic [H_BITS-1:0] meas_h_active,
  output logic [V_BITS-1:0] meas_v_total,
  output logic [V_BITS-1:0] meas_v_active,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_hact,
  output logic [15:0]       crc
);

  logic hs_q, vs_q, vld_q, hs_q2, vs_q2, vld_q2, hs_rise_q, vs_rise_q;
  state_t state_q, state_d;
  logic [H_BITS-1:0] h_cnt_q, h_cnt_d, h_total_q, h_total_d;
  logic [H_BITS-1:0] line_vld_q, line_vld_d, hact_q, hact_d;
  logic [V_BITS-1:0] v_cnt_q, v_cnt_d, v_act_q, v_act_d;
  logic              hact_seen_q, hact_seen_d, err_q, err_d;
  logic              meas_vld_q, meas_vld_d, meas_err_q, meas_err_d;
  logic [H_BITS-1:0] meas_ht_q, meas_ht_d, meas_ha_q, meas_ha_d;
  logic [V_BITS-1:0] meas_vt_q, meas_vt_d, meas_va_q, meas_va_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Rise pulses are registered so that vld_q2 lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {hs_q, vs_q, vld_q, hs_q2, vs_q2, vld_q2, hs_rise_q, vs_rise_q} <= '0;
    end else begin
      hs_q      <= hs;
      vs_q      <= vs;
      vld_q     <= vld;
      hs_q2     <= hs_q;
      vs_q2     <= vs_q;
      vld_q2    <= vld_q;
      hs_rise_q <= hs_q & ~hs_q2;
      vs_rise_q <= vs_q & ~vs_q2;
    end
  end

  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    h_total_d   = h_total_q;
    line_vld_d  = line_vld_q;
    hact_d      = hact_q;
    hact_seen_d = hact_seen_q;
    v_cnt_d     = v_cnt_q;
    v_act_d     = v_act_q;
    err_d       = err_q;
    meas_vld_d  = 1'b0;
    meas_ht_d   = meas_ht_q;
    meas_ha_d   = meas_ha_q;
    meas_vt_d   = meas_vt_q;
    meas_va_d   = meas_va_q;
    meas_err_d  = meas_err_q;
    fcnt_d      = fcnt_q;
    unique case (state_q)
      S_SYNC: begin
        h_cnt_d     = '0;
        h_total_d   = '0;
        line_vld_d  = '0;
        hact_d      = '0;
        hact_seen_d = 1'b0;
        v_cnt_d     = '0;
        v_act_d     = '0;
        err_d       = 1'b0;
        if (vs_rise_q) begin
          state_d = S_MEAS;
          h_cnt_d = H_BITS'(1);
        end
      end
      S_MEAS: begin
        h_cnt_d = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + H_BITS'(1);
        if (vld_q2 && line_vld_q != '1) line_vld_d = line_vld_q + H_BITS'(1);
        if (hs_rise_q) begin
          h_total_d = h_cnt_q;
          h_cnt_d   = H_BITS'(1);
          if (v_cnt_q != '1) v_cnt_d = v_cnt_q + V_BITS'(1);
          if (line_vld_q != '0) begin
            if (v_act_q != '1) v_act_d = v_act_q + V_BITS'(1);
            if (!hact_seen_q) begin
              hact_d      = line_vld_q;
              hact_seen_d = 1'b1;
            end else if (line_vld_q != hact_q) begin
              err_d = 1'b1;
            end
          end
          // A pixel coincident with hs belongs to the new line.
          line_vld_d = vld_q2 ? H_BITS'(1) : '0;
        end
        // Frame close sees the line-close results above (hs before vs).
        if (vs_rise_q) begin
          meas_vld_d  = 1'b1;
          meas_ht_d   = h_total_d;
          meas_ha_d   = hact_d;
          meas_vt_d   = v_cnt_d;
          meas_va_d   = v_act_d;
          meas_err_d  = err_d;
          fcnt_d      = fcnt_q + FCNT_W'(1);
          h_total_d   = '0;
          line_vld_d  = '0;
          hact_d      = '0;
          hact_seen_d = 1'b0;
          v_cnt_d     = '0;
          v_act_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      h_cnt_q     <= '0;
      h_total_q   <= '0;
      line_vld_q  <= '0;
      hact_q      <= '0;
      hact_seen_q <= 1'b0;
      v_cnt_q     <= '0;
      v_act_q     <= '0;
      err_q       <= 1'b0;
      meas_vld_q  <= 1'b0;
      meas_ht_q   <= '0;
      meas_ha_q   <= '0;
      meas_vt_q   <= '0;
      meas_va_q   <= '0;
      meas_err_q  <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      h_total_q   <= h_total_d;
      line_vld_q  <= line_vld_d;
      hact_q      <= hact_d;
      hact_seen_q <= hact_seen_d;
      v_cnt_q     <= v_cnt_d;
      v_act_q     <= v_act_d;
      err_q       <= err_d;
      meas_vld_q  <= meas_vld_d;
      meas_ht_q   <= meas_ht_d;
      meas_ha_q   <= meas_ha_d;
      meas_vt_q   <= meas_vt_d;
      meas_va_q   <= meas_va_d;
      meas_err_q  <= meas_err_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign meas_vld      = meas_vld_q;
  assign meas_h_total  = meas_ht_q;
  assign meas_h_active = meas_ha_q;
  assign meas_v_total  = meas_vt_q;
  assign meas_v_active = meas_va_q;
  assign frame_cnt     = fcnt_q;
  assign err_hact      = meas_err_q;

`ifdef VTM_CRC_EN
  logic [3*PW-1:0] rgb_q, rgb_q2;
  logic [15:0]     crc_q, crc_d, crc_out_q, crc_out_d, crc_nxt, crc_word;

  vtm_crc16 #(
    .W (3 * PW)
  ) u_crc16 (
    .crc_in  (crc_q),
    .data    (rgb_q2),
    .crc_out (crc_nxt)
  );

  always_comb begin
    crc_word  = vld_q2 ? crc_nxt : crc_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    if (state_q == S_SYNC) begin
      crc_d = CRC_INIT;
    end else begin
      crc_d = crc_word;
      if (vs_rise_q) begin
        crc_out_d = crc_word;
        crc_d     = CRC_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      rgb_q2    <= '0;
      crc_q     <= CRC_INIT;
      crc_out_q <= '0;
    end else begin
      rgb_q     <= rgb;
      rgb_q2    <= rgb_q;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign crc = crc_out_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign crc        = 16'h0;
`endif

endmodule

// File: tb/tb_vid_timing_monitor.sv
// Directed bench: 100x50 timing with 80x40 active area, drop-pixel error, no-hs frames, mid-frame reset.
module tb_vid_timing_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b0, vs = 1'b0, vld = 1'b0;
  logic [23:0] rgb = 24'h0;
  logic        meas_vld, err_hact;
  logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic [15:0] frame_cnt, crc;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0, rise_cyc = -100, pulses = 0, lat = -1, base;
  logic vs_prev = 1'b0;

  vid_timing_monitor #(
    .PW     (8),
    .H_BITS (12),
    .V_BITS (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs            (hs),
    .vs            (vs),
    .vld           (vld),
    .rgb           (rgb),
    .meas_vld      (meas_vld),
    .meas_h_total  (meas_h_total),
    .meas_h_active (meas_h_active),
    .meas_v_total  (meas_v_total),
    .meas_v_active (meas_v_active),
    .frame_cnt     (frame_cnt),
    .err_hact      (err_hact),
    .crc           (crc)
  );

  always #5 clk = ~clk;

  // Pulse monitor: latency is counted from the edge that first samples vs=1.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (vs && !vs_prev) rise_cyc = cyc;
    vs_prev = vs;
    #1;
    if (meas_vld) begin
      pulses++;
      lat = cyc - rise_cyc;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] crc_px(input logic [15:0] c_in, input logic [23:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic int exp_crc(input int npix);
`ifdef VTM_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < npix; i++) c = crc_px(c, 24'h0);
    return int'(c);
`else
    return (npix < 0) ? 1 : 0;
`endif
  endfunction

  task automatic gen_frame(input int drop_v, input int nlines);
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < 100; h++) begin
        @(negedge clk);
        hs  = (h < 4);
        vs  = (v < 2);
        vld = (v >= 5 && v <= 44 && h >= 10 && h <= 89) &&
              !(v == drop_v && h >= 40 && h < 43);
      end
    end
  endtask

  task automatic gen_quiet();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hs  = 1'b0;
      vs  = (i < 2);
      vld = 1'b0;
    end
  endtask

  task automatic check_rec(input string tag, input int ht, input int ha, input int vt,
                           input int va, input int fc, input int er);
    check_eq({tag, "_h_total"}, int'(meas_h_total), ht);
    check_eq({tag, "_h_active"}, int'(meas_h_active), ha);
    check_eq({tag, "_v_total"}, int'(meas_v_total), vt);
    check_eq({tag, "_v_active"}, int'(meas_v_active), va);
    check_eq({tag, "_frame_cnt"}, int'(frame_cnt), fc);
    check_eq({tag, "_err_hact"}, int'(err_hact), er);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_rec("rst", 0, 0, 0, 0, 0, 0);
    check_eq("rst_meas_vld", int'(meas_vld), 0);
    check_eq("rst_crc", int'(crc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    gen_frame(-1, 50);
    check_eq("first_vs_no_pulse", pulses, 0);
    gen_frame(-1, 50);
    check_eq("f1_pulses", pulses, 1);
    check_eq("f1_latency", lat, 2);
    check_rec("f1", 100, 80, 50, 40, 1, 0);
    check_eq("f1_crc", int'(crc), exp_crc(3200));

    gen_frame(12, 50);
    check_eq("f2_pulses", pulses, 2);
    check_rec("f2", 100, 80, 50, 40, 2, 0);
    gen_frame(-1, 50);
    check_rec("f3_drop", 100, 80, 50, 40, 3, 1);
    check_eq("f3_crc", int'(crc), exp_crc(3197));
    gen_frame(-1, 50);
    check_rec("f4_clean", 100, 80, 50, 40, 4, 0);
    check_eq("f4_crc", int'(crc), exp_crc(3200));
    check_eq("f4_latency", lat, 2);

    // Frame ended by vs with no coincident hs: the last line stays open.
    gen_quiet();
    check_rec("f5_open_line", 100, 80, 49, 40, 5, 0);
    gen_quiet();
    check_rec("f6_no_hs", 0, 0, 0, 0, 6, 0);
    check_eq("f6_crc", int'(crc), exp_crc(0));
    check_eq("f6_pulses", pulses, 6);

    gen_frame(-1, 25);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_rec("mid_rst", 0, 0, 0, 0, 0, 0);
    check_eq("mid_rst_crc", int'(crc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = pulses;
    gen_frame(-1, 50);
    check_eq("post_rst_no_pulse", pulses - base, 0);
    gen_frame(-1, 50);
    check_eq("post_rst_pulse", pulses - base, 1);
    check_eq("post_rst_latency", lat, 2);
    check_rec("post_rst", 100, 80, 50, 40, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
